// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - execute-stage ALU: single-cycle logic/arith, iterative unsigned mul/div
module alu_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int CTRL_WIDTH  = 4,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] ALUop1,
    input  logic [DATA_WIDTH-1:0] ALUop2,
    input  logic [CTRL_WIDTH-1:0] ALUctrl,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] ALUout,
    output logic                  EQ
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [CTRL_WIDTH-1:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,
                                      OP_OR  = 4'd3,  OP_XOR = 4'd4,  OP_SLT = 4'd5,
                                      OP_SLTU = 4'd6, OP_SLL = 4'd7,  OP_SRL = 4'd8,
                                      OP_SRA = 4'd9,  OP_MUL = 4'd10, OP_MULHU = 4'd11,
                                      OP_DIVU = 4'd12, OP_REMU = 4'd13;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*W-1:0]     acc_q, acc_d, step_acc;
    logic [W-1:0]       opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               want_hi_q, want_hi_d;
    logic               eqp_q, eqp_d;
    logic [W-1:0]       out_q, out_d;
    logic               eq_q, eq_d;
    logic               ov_q, ov_d;

    logic [W-1:0]       fast_res;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic               accept, slow_op;
    logic [W:0]         mul_sum, div_rem, div_diff;

    assign shamt   = ALUop2[SHAMT_WIDTH-1:0];
    assign accept  = in_valid && (state_q == IDLE) && !flush;
    assign slow_op = (ALUctrl == OP_MUL) || (ALUctrl == OP_MULHU) ||
                     (((ALUctrl == OP_DIVU) || (ALUctrl == OP_REMU)) && (|ALUop2));

    always_comb begin
        fast_res = '0;
        case (ALUctrl)
            OP_ADD:  fast_res = ALUop1 + ALUop2;
            OP_SUB:  fast_res = ALUop1 - ALUop2;
            OP_AND:  fast_res = ALUop1 & ALUop2;
            OP_OR:   fast_res = ALUop1 | ALUop2;
            OP_XOR:  fast_res = ALUop1 ^ ALUop2;
            OP_SLT:  fast_res = {{(W-1){1'b0}}, $signed(ALUop1) < $signed(ALUop2)};
            OP_SLTU: fast_res = {{(W-1){1'b0}}, ALUop1 < ALUop2};
            OP_SLL:  fast_res = ALUop1 << shamt;
            OP_SRL:  fast_res = ALUop1 >> shamt;
            OP_SRA:  fast_res = $signed(ALUop1) >>> shamt;
            OP_DIVU: fast_res = '1;        // only reached with a zero divisor
            OP_REMU: fast_res = ALUop1;
            default: fast_res = '0;
        endcase
    end

    // Multiply: acc = {partial, multiplier}, add on LSB then shift right.
    // Divide: acc = {remainder, dividend}, shift left then restoring subtract.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_rem  = acc_q[2*W-1:W-1];
        div_diff = div_rem - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!div_diff[W])
                step_acc = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            else
                step_acc = {div_rem[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            step_acc = {mul_sum, acc_q[W-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        want_hi_d = want_hi_q;
        eqp_d     = eqp_q;
        out_d     = out_q;
        eq_d      = eq_q;
        ov_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (slow_op) begin
                        state_d   = BUSY;
                        cnt_d     = CW'(W - 1);
                        acc_d     = {{W{1'b0}}, ALUop1};
                        opnd_d    = ALUop2;
                        is_div_d  = ALUctrl[2];
                        want_hi_d = ALUctrl[0];
                        eqp_d     = (ALUop1 == ALUop2);
                    end else begin
                        out_d = fast_res;
                        eq_d  = (ALUop1 == ALUop2);
                        ov_d  = 1'b1;
                    end
                end
            end
            BUSY: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    out_d   = want_hi_q ? step_acc[2*W-1:W] : step_acc[W-1:0];
                    eq_d    = eqp_q;
                    ov_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = out_q;
            eq_d    = eq_q;
            ov_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            want_hi_q <= 1'b0;
            eqp_q     <= 1'b0;
            out_q     <= '0;
            eq_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            want_hi_q <= want_hi_d;
            eqp_q     <= eqp_d;
            out_q     <= out_d;
            eq_q      <= eq_d;
            ov_q      <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign ALUout    = out_q;
    assign EQ        = eq_q;
endmodule
